lifo_drain_ctrl: RTL and testbench

Pop-side controller that sits directly downstream of the parameterized LIFO buffer. On a start command it pops a programmable number of entries (or all of them), captures each popped word into a 2-entry skid buffer, and presents the words to the next stage over a valid/ready handshake. Words leave in LIFO order (top first), with full throughput and no loss under backpressure.

---
 rtl/lifo_drain_pkg.sv | 16 +
 rtl/lifo_skid2.sv | 65 ++++++
 rtl/lifo_drain_ctrl.sv | 115 +++++++++++
 tb/tb_lifo_drain_ctrl.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lifo_drain_pkg.sv
// Shared types for the LIFO drain controller: FSM state encoding and skid-buffer fill type.
package lifo_drain_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2
  } drain_state_e;

  typedef logic [1:0] fill_t;

  localparam fill_t FILL_EMPTY = 2'd0;
  localparam fill_t FILL_ONE   = 2'd1;
  localparam fill_t FILL_FULL  = 2'd2;

endpackage

// File: rtl/lifo_skid2.sv
// Two-entry skid buffer: accepts one word per cycle and presents the oldest word on a valid/ready port.
module lifo_skid2
  import lifo_drain_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] data_in,
  output logic              valid,
  input  logic              ready,
  output logic [DATA_W-1:0] data_out,
  output fill_t             fill
);

  logic [DATA_W-1:0] ent0_q;
  logic [DATA_W-1:0] ent1_q;
  fill_t             fill_q;
  logic              pop;

  assign valid    = (fill_q != FILL_EMPTY);
  assign data_out = ent0_q;
  assign fill     = fill_q;
  assign pop      = valid & ready;

  // ent0 is always the oldest word; a pop shifts ent1 down.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the storage words are reset too, because out_data must read 0 out of reset,
      // not just be qualified by out_valid.
      ent0_q <= '0;
      ent1_q <= '0;
      fill_q <= FILL_EMPTY;
    end else begin
      // NOTE: non-blocking assignments so every register here samples pre-edge values,
      // which is what makes the ent1 -> ent0 shift and the fill update order-independent.
      case ({push, pop})
        2'b10: begin
          if (fill_q == FILL_EMPTY) begin
            ent0_q <= data_in;
            fill_q <= FILL_ONE;
          end else if (fill_q == FILL_ONE) begin
            ent1_q <= data_in;
            fill_q <= FILL_FULL;
          end
        end
        2'b01: begin
          ent0_q <= ent1_q;
          fill_q <= fill_q - 2'd1;
        end
        2'b11: begin
          if (fill_q == FILL_FULL) begin
            ent0_q <= ent1_q;
            ent1_q <= data_in;
          end else begin
            ent0_q <= data_in;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/lifo_drain_ctrl.sv
// Pop-side LIFO drain controller: pops len entries (0 = until empty) into a skid buffer.
// Optional pop counter enabled by defining LIFO_DRAIN_CNT_EN; otherwise pop_cnt reads 0.
module lifo_drain_ctrl
  import lifo_drain_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CNT_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  pop_cnt,
  input  logic              lifo_val,
  input  logic [DATA_W-1:0] lifo_data,
  input  logic              lifo_wr,
  output logic              lifo_read,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  drain_state_e      state_q;
  drain_state_e      state_d;
  logic [CNT_W-1:0]  rem_q;
  logic              unlimited_q;
  logic              done_q;
  logic              load;
  logic              pop_allow;
  fill_t             fill;

  assign load      = (state_q == IDLE) & start;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  // A read coinciding with an upstream write would replace the top instead of popping it.
  assign pop_allow = lifo_val & ~lifo_wr & (fill != FILL_FULL)
                   & (unlimited_q | (rem_q != '0));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    state_d   = state_q;
    lifo_read = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = DRAIN;
      end
      DRAIN: begin
        lifo_read = pop_allow;
        if ((!unlimited_q && (((rem_q == CNT_W'(1)) && pop_allow) || (rem_q == '0)))
            || !lifo_val)
          state_d = FLUSH;
      end
      FLUSH: begin
        if (fill == FILL_EMPTY) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rem_q       <= '0;
      unlimited_q <= 1'b0;
    end else if (load) begin
      rem_q       <= len;
      unlimited_q <= (len == '0);
    end else if (lifo_read && !unlimited_q) begin
      rem_q       <= rem_q - CNT_W'(1);
    end
  end

  // done lands in the cycle after the skid has emptied in FLUSH, together with busy falling.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) done_q <= 1'b0;
    else        done_q <= (state_q == FLUSH) && (fill == FILL_EMPTY);
  end

`ifdef LIFO_DRAIN_CNT_EN
  logic [CNT_W-1:0] pop_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         pop_cnt_q <= '0;
    else if (load)      pop_cnt_q <= '0;
    else if (lifo_read) pop_cnt_q <= pop_cnt_q + CNT_W'(1);
  end

  assign pop_cnt = pop_cnt_q;
`else
  assign pop_cnt = '0;
`endif

  lifo_skid2 #(
    .DATA_W (DATA_W)
  ) u_skid (
    .clk      (clk),
    .reset    (reset),
    .push     (lifo_read),
    .data_in  (lifo_data),
    .valid    (out_valid),
    .ready    (out_ready),
    .data_out (out_data),
    .fill     (fill)
  );

  a_no_pop_when_full : assert property (
    @(posedge clk) disable iff (!reset) !(lifo_read && (fill == FILL_FULL)));

endmodule

// File: tb/tb_lifo_drain_ctrl.sv
// Directed self-checking bench for lifo_drain_ctrl, driven by a small behavioural LIFO.
module tb_lifo_drain_ctrl;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic [CNT_W-1:0]  len = '0;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  pop_cnt;
  logic              lifo_val;
  logic [DATA_W-1:0] lifo_data;
  logic              lifo_wr = 1'b0;
  logic              lifo_read;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready = 1'b0;

  // Behavioural LIFO
  logic [DATA_W-1:0] stk [0:15];
  logic [3:0]        sp = 4'd0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              lifo_clr = 1'b0;

  int checks = 0;
  int failures = 0;
  int reads, dones, vseen, stall_changes;
  logic              prev_stall;
  logic [DATA_W-1:0] prev_data;
  logic [DATA_W-1:0] got[$];
  logic [DATA_W-1:0] exp_q[$];

  always #5 clk = ~clk;

  assign lifo_val  = (sp != 4'd0);
  assign lifo_data = (sp != 4'd0) ? stk[sp - 4'd1] : '0;

  always @(posedge clk) begin
    if (lifo_clr) begin
      sp <= 4'd0;
    end else if (lifo_wr) begin
      if (lifo_read && sp != 4'd0) stk[sp - 4'd1] <= wr_data;
      else begin
        stk[sp] <= wr_data;
        sp      <= sp + 4'd1;
      end
    end else if (lifo_read && sp != 4'd0) begin
      sp <= sp - 4'd1;
    end
  end

  lifo_drain_ctrl #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .pop_cnt   (pop_cnt),
    .lifo_val  (lifo_val),
    .lifo_data (lifo_data),
    .lifo_wr   (lifo_wr),
    .lifo_read (lifo_read),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  task automatic check(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    checks++;
    if (got_v !== exp_v) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got_v, exp_v);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic lifo_push(input logic [DATA_W-1:0] d);
    lifo_wr = 1'b1;
    wr_data = d;
    cyc();
    lifo_wr = 1'b0;
  endtask

  task automatic lifo_clear();
    lifo_clr = 1'b1;
    cyc();
    lifo_clr = 1'b0;
  endtask

  task automatic sample();
    reads += 32'(lifo_read);
    dones += 32'(done);
    vseen += 32'(out_valid);
    if (prev_stall && (out_data != prev_data)) stall_changes++;
    prev_stall = out_valid & ~out_ready;
    prev_data  = out_data;
    if (out_valid && out_ready) got.push_back(out_data);
  endtask

  task automatic run_collect(input int n);
    for (int i = 0; i < n; i++) begin
      #1;
      sample();
      cyc();
    end
  endtask

  task automatic do_start(input logic [CNT_W-1:0] l);
    reads = 0; dones = 0; vseen = 0; stall_changes = 0;
    prev_stall = 1'b0;
    got.delete();
    start = 1'b1;
    len   = l;
    cyc();
    start = 1'b0;
    len   = 4'hF;
  endtask

  task automatic check_got(input string tag);
    check({tag, "_n"}, 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (i < got.size()) check($sformatf("%s[%0d]", tag, i), 32'(got[i]), 32'(exp_q[i]));
  endtask

  function automatic logic [31:0] exp_cnt(input int n);
`ifdef LIFO_DRAIN_CNT_EN
    return 32'(n);
`else
    return 32'(n * 0);
`endif
  endfunction

  initial begin
    // Reset state
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pop_cnt", 32'(pop_cnt), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_lifo_read", 32'(lifo_read), 32'd0);
    cyc();
    reset = 1'b1;
    cyc();

    // T1: drain-all, full throughput, exact cycle timing
    lifo_push(8'h11); lifo_push(8'h22); lifo_push(8'h33);
    out_ready = 1'b1;
    start = 1'b1; len = '0;
    #1;
    check("t1_c0_busy", 32'(busy), 32'd0);
    for (int c = 1; c <= 7; c++) begin
      cyc();
      start = 1'b0;
      #1;
      case (c)
        1: begin
          check("t1_c1_valid", 32'(out_valid), 32'd0);
          check("t1_c1_read", 32'(lifo_read), 32'd1);
          check("t1_c1_busy", 32'(busy), 32'd1);
        end
        2: begin
          check("t1_c2_valid", 32'(out_valid), 32'd1);
          check("t1_c2_data", 32'(out_data), 32'h33);
        end
        3: check("t1_c3_data", 32'(out_data), 32'h22);
        4: begin
          check("t1_c4_valid", 32'(out_valid), 32'd1);
          check("t1_c4_data", 32'(out_data), 32'h11);
        end
        5: begin
          check("t1_c5_valid", 32'(out_valid), 32'd0);
          check("t1_c5_done", 32'(done), 32'd0);
          check("t1_c5_busy", 32'(busy), 32'd1);
        end
        6: begin
          check("t1_c6_done", 32'(done), 32'd1);
          check("t1_c6_busy", 32'(busy), 32'd0);
        end
        default: check("t1_c7_done", 32'(done), 32'd0);
      endcase
    end
    check("t1_pop_cnt", 32'(pop_cnt), exp_cnt(3));
    check("t1_lifo_val", 32'(lifo_val), 32'd0);

    // T2: limited burst of 2 out of 5
    lifo_clear();
    lifo_push(8'hA1); lifo_push(8'hA2); lifo_push(8'hA3); lifo_push(8'hA4); lifo_push(8'hA5);
    out_ready = 1'b1;
    do_start(4'd2);
    run_collect(10);
    check("t2_reads", 32'(reads), 32'd2);
    check("t2_dones", 32'(dones), 32'd1);
    check("t2_left", 32'(sp), 32'd3);
    check("t2_pop_cnt", 32'(pop_cnt), exp_cnt(2));
    exp_q = '{8'hA5, 8'hA4};
    check_got("t2_out");

    // T3: backpressure stalls after 2 pops, data held, then in-order completion
    lifo_clear();
    lifo_push(8'hB1); lifo_push(8'hB2); lifo_push(8'hB3); lifo_push(8'hB4);
    out_ready = 1'b0;
    do_start(4'd0);
    run_collect(10);
    check("t3_stall_reads", 32'(reads), 32'd2);
    check("t3_stall_valid", 32'(out_valid), 32'd1);
    check("t3_stall_data", 32'(out_data), 32'hB4);
    check("t3_stall_nout", 32'(got.size()), 32'd0);
    out_ready = 1'b1;
    run_collect(10);
    check("t3_reads", 32'(reads), 32'd4);
    check("t3_held", 32'(stall_changes), 32'd0);
    check("t3_dones", 32'(dones), 32'd1);
    exp_q = '{8'hB4, 8'hB3, 8'hB2, 8'hB1};
    check_got("t3_out");

    // T4: upstream writes during cycles 2-3 suppress pops and join the stack
    lifo_clear();
    lifo_push(8'hC1); lifo_push(8'hC2); lifo_push(8'hC3);
    out_ready = 1'b1;
    do_start(4'd0);
    run_collect(1);
    lifo_wr = 1'b1; wr_data = 8'hD0;
    #1;
    check("t4_c2_read", 32'(lifo_read), 32'd0);
    sample();
    cyc();
    wr_data = 8'hD1;
    #1;
    check("t4_c3_read", 32'(lifo_read), 32'd0);
    sample();
    cyc();
    lifo_wr = 1'b0;
    run_collect(12);
    check("t4_reads", 32'(reads), 32'd5);
    check("t4_dones", 32'(dones), 32'd1);
    exp_q = '{8'hC3, 8'hD1, 8'hD0, 8'hC2, 8'hC1};
    check_got("t4_out");

    // T5: empty LIFO at start
    lifo_clear();
    out_ready = 1'b1;
    do_start(4'd3);
    run_collect(8);
    check("t5_valid_seen", 32'(vseen), 32'd0);
    check("t5_reads", 32'(reads), 32'd0);
    check("t5_dones", 32'(dones), 32'd1);
    check("t5_pop_cnt", 32'(pop_cnt), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);

    // T6: asynchronous reset with a full skid, then a single-entry burst
    lifo_clear();
    lifo_push(8'hE1); lifo_push(8'hE2); lifo_push(8'hE3); lifo_push(8'hE4);
    out_ready = 1'b0;
    do_start(4'd0);
    run_collect(2);
    #1;
    check("t6_pre_valid", 32'(out_valid), 32'd1);
    check("t6_pre_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    check("t6_rst_valid", 32'(out_valid), 32'd0);
    check("t6_rst_read", 32'(lifo_read), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_data", 32'(out_data), 32'd0);
    cyc();
    cyc();
    reset = 1'b1;
    cyc();
    out_ready = 1'b1;
    do_start(4'd1);
    run_collect(8);
    check("t6_reads", 32'(reads), 32'd1);
    check("t6_dones", 32'(dones), 32'd1);
    check("t6_left", 32'(sp), 32'd1);
    exp_q = '{8'hE2};
    check_got("t6_out");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
